// File: rtl/csa_pkg.sv
// Shared types and constants for the multi-word carry-select adder sequencer.
package csa_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } csa_seq_state_t;

endpackage

// File: rtl/csa16_slice.sv
// 16-bit carry-select adder slice: the low byte ripples, while the high byte is
// computed for both carry values and the low-byte carry picks one.
module csa16_slice
    import csa_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int HALF = SLICE_W / 2;

    logic [HALF:0] lo;
    logic [HALF:0] hi0;
    logic [HALF:0] hi1;

    assign lo  = {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, cin};
    assign hi0 = {1'b0, a[SLICE_W-1:HALF]} + {1'b0, b[SLICE_W-1:HALF]};
    assign hi1 = {1'b0, a[SLICE_W-1:HALF]} + {1'b0, b[SLICE_W-1:HALF]} + {{HALF{1'b0}}, 1'b1};

    assign sum  = {(lo[HALF] ? hi1[HALF-1:0] : hi0[HALF-1:0]), lo[HALF-1:0]};
    assign cout = lo[HALF] ? hi1[HALF] : hi0[HALF];

endmodule

// File: rtl/csa_wide_add_seq.sv
// WORDS*16-bit adder that reuses one 16-bit carry-select slice, LSB slice first.
// Optional subtract mode (in_op port) is enabled by defining CSA_WADD_SUB_EN.
module csa_wide_add_seq
    import csa_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORDS*SLICE_W-1:0] in_a,
    input  logic [WORDS*SLICE_W-1:0] in_b,
`ifdef CSA_WADD_SUB_EN
    input  logic                     in_op,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*SLICE_W-1:0] out_sum,
    output logic                     out_cout,
    output logic                     busy
);

    localparam int W     = WORDS * SLICE_W;
    localparam int IDX_W = $clog2(WORDS) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    csa_seq_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;

    logic               sub_w;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

`ifdef CSA_WADD_SUB_EN
    assign sub_w = in_op;
`else
    assign sub_w = 1'b0;
`endif

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                slice_b = b_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    csa16_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1, so the inverted operand and the +1 are set up here.
                    a_d     = in_a;
                    b_d     = sub_w ? ~in_b : in_b;
                    carry_d = sub_w;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    cout_d  = slice_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_csa_wide_add_seq.sv
// Directed and randomised checks of csa_wide_add_seq with WORDS=4.
module tb_csa_wide_add_seq;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csa_wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef CSA_WADD_SUB_EN
        .in_op     (in_op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair, wait for acceptance, then count edges until out_valid.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                         output int lat);
        int n;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk("accept_timeout", 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!out_valid) chk("result_timeout", 1'b0, 1'b1);
    endtask

    task automatic collect();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [W-1:0] hold_sum;
        logic         hold_cout;
        logic [W-1:0] ra, rb;
        logic         rop;
        logic [W:0]   model;

        #12;
        chk("rst_out_valid", {64'd0, out_valid}, 65'd0);
        chk("rst_in_ready",  {64'd0, in_ready},  65'd1);
        chk("rst_busy",      {64'd0, busy},      65'd0);
        chk("rst_sum_cout",  {out_cout, out_sum}, 65'd0);
        rst_n = 1'b1;
        step();

        // 1: simple add and latency
        issue(64'd1, 64'd1, 1'b0, lat);
        chk("t1_latency", 65'(lat), 65'd4);
        chk("t1_result", {out_cout, out_sum}, {1'b0, 64'h2});
        chk("t1_busy", {64'd0, busy}, 65'd1);
        collect();
        chk("t1_idle", {64'd0, in_ready}, 65'd1);

        // 2: carry ripples through every slice
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
        chk("t2_result", {out_cout, out_sum}, {1'b1, 64'h0});

        // 3: back-pressure in DONE; in_valid must be ignored
        hold_sum  = out_sum;
        hold_cout = out_cout;
        in_a = 64'hAAAA; in_b = 64'h5555;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            step();
            chk("t3_valid_held", {64'd0, out_valid}, 65'd1);
            chk("t3_in_ready", {64'd0, in_ready}, 65'd0);
            chk("t3_stable", {out_cout, out_sum}, {hold_cout, hold_sum});
        end
        in_valid = 1'b0;
        collect();
        chk("t3_after_release", {63'd0, busy, out_valid}, 65'd0);
        chk("t3_result_kept", {out_cout, out_sum}, {1'b1, 64'h0});
        step();
        chk("t3_no_accept", {64'd0, busy}, 65'd0);

        // 4: reset during RUN discards the op
        in_a = 64'h1111; in_b = 64'h2222; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("t4_running", {64'd0, busy}, 65'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", {64'd0, out_valid}, 65'd0);
        chk("t4_rst_ready", {64'd0, in_ready}, 65'd1);
        chk("t4_rst_sum", {out_cout, out_sum}, 65'd0);
        step();
        rst_n = 1'b1;
        step();
        issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, lat);
        chk("t4_latency", 65'(lat), 65'd4);
        chk("t4_result", {out_cout, out_sum}, {1'b0, 64'h2222_2222_2222_2211});
        collect();

        // boundary: carry out of MSB slice with nonzero sum
        issue(64'h8000_0000_0000_0001, 64'h8000_0000_0000_FFFF, 1'b0, lat);
        chk("msb_carry", {out_cout, out_sum}, {1'b1, 64'h0000_0000_0001_0000});
        collect();

`ifdef CSA_WADD_SUB_EN
        // 5: subtract
        issue(64'd0, 64'd1, 1'b1, lat);
        chk("t5_sub_borrow", {out_cout, out_sum}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        collect();
        issue(64'd5, 64'd3, 1'b1, lat);
        chk("t5_sub_plain", {out_cout, out_sum}, {1'b1, 64'h2});
        collect();
`endif

        // 6: random back-to-back ops with random consumer stalls
        for (int k = 0; k < 200; k++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (k % 7 == 0) rb = ~ra;
            rop = 1'b0;
`ifdef CSA_WADD_SUB_EN
            rop = 1'($urandom_range(0, 1));
`endif
            if (rop) model = {1'b0, ra} + {1'b0, ~rb} + 65'd1;
            else     model = {1'b0, ra} + {1'b0, rb};
            issue(ra, rb, rop, lat);
            chk("rnd_latency", 65'(lat), 65'd4);
            chk("rnd_result", {out_cout, out_sum}, model);
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) step();
            collect();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
